// File: rtl/alu_pkg.sv
// Shared types for the execute unit: ALU select codes, R-type function
// codes, FSM states and the alu_op/func decoder.
package alu_pkg;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  // Low three bits keep the classic single-cycle ALU encoding.
  typedef enum logic [3:0] {
    SEL_AND  = 4'b0000,
    SEL_OR   = 4'b0001,
    SEL_ADD  = 4'b0010,
    SEL_SRLV = 4'b0011,
    SEL_SUB  = 4'b0110,
    SEL_SLT  = 4'b0111,
    SEL_MUL  = 4'b1000,
    SEL_DIV  = 4'b1001,
    SEL_MFHI = 4'b1010,
    SEL_MFLO = 4'b1011,
    SEL_ILL  = 4'b1111
  } alu_sel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } alu_state_t;

  function automatic alu_sel_t decode_op(input logic [1:0] alu_op,
                                         input logic [5:0] func);
    alu_sel_t sel;
    sel = SEL_ILL;
    case (alu_op)
      2'b00: sel = SEL_ADD;
      2'b01: sel = SEL_SUB;
      2'b10: begin
        case (func)
          FN_ADD:   sel = SEL_ADD;
          FN_SUB:   sel = SEL_SUB;
          FN_AND:   sel = SEL_AND;
          FN_OR:    sel = SEL_OR;
          FN_SLT:   sel = SEL_SLT;
          FN_SRLV:  sel = SEL_SRLV;
          FN_MFHI:  sel = SEL_MFHI;
          FN_MFLO:  sel = SEL_MFLO;
          FN_MULTU: sel = SEL_MUL;
          FN_DIVU:  sel = SEL_DIV;
          default:  sel = SEL_ILL;
        endcase
      end
      default: sel = SEL_ILL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle, sharing a single 2*WIDTH working register; owns the HI/LO registers.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic               run;
  logic               div_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] work;
  logic [2*WIDTH-1:0] work_nxt;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     msum;

  // Multiply: work = {partial, multiplier}; divide: work = {remainder, quotient}.
  always_comb begin
    diff = work[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    msum = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    work_nxt = work;
    if (div_q) begin
      if (!diff[WIDTH]) work_nxt = {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      else              work_nxt = {work[2*WIDTH-2:0], 1'b0};
    end else begin
      work_nxt = {msum, work[WIDTH-1:1]};
    end
  end

  assign fin = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      div_q <= 1'b0;
      cnt   <= '0;
      opnd  <= '0;
      work  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (go) begin
      div_q <= is_div;
      cnt   <= '0;
      opnd  <= is_div ? b : a;
      work  <= {{WIDTH{1'b0}}, (is_div ? a : b)};
      // Divide by zero skips iteration and resolves immediately.
      if (is_div && (b == '0)) begin
        run <= 1'b0;
        hi  <= a;
        lo  <= '1;
      end else begin
        run <= 1'b1;
      end
    end else if (run) begin
      work <= work_nxt;
      cnt  <= cnt + CW'(1);
      if (fin) begin
        run <= 1'b0;
        hi  <= work_nxt[2*WIDTH-1:WIDTH];
        lo  <= work_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute unit: alu_op/func decode, single-cycle ALU, result register and
// start/done handshake around the iterative multiply/divide engine.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  alu_state_t       state, state_nxt;
  alu_sel_t         sel;
  logic             accept;
  logic             go;
  logic             is_div;
  logic             fin;
  logic [WIDTH-1:0] alu_out;

  assign sel    = decode_op(alu_op, func);
  assign accept = (state == ST_IDLE) && start;
  assign is_div = (sel == SEL_DIV);
  assign go     = accept && ((sel == SEL_MUL) || is_div);
  assign zero   = (result == '0);

  always_comb begin
    alu_out = '0;
    case (sel)
      SEL_ADD:  alu_out = a + b;
      SEL_SUB:  alu_out = a - b;
      SEL_AND:  alu_out = a & b;
      SEL_OR:   alu_out = a | b;
      SEL_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SEL_SRLV: alu_out = b >> a[SH_W-1:0];
      SEL_MFHI: alu_out = hi;
      SEL_MFLO: alu_out = lo;
      default:  alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (sel == SEL_MUL)                state_nxt = ST_MUL;
          else if (is_div && (b != '0))      state_nxt = ST_DIV;
          else                               state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (fin) state_nxt = ST_DONE;
      ST_DONE:        state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Multiply/divide leave result untouched; illegal ops fall to the zero default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result  <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      illegal <= (sel == SEL_ILL);
      if (!go) result <= alu_out;
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .is_div (is_div),
    .a      (a),
    .b      (b),
    .fin    (fin),
    .hi     (hi),
    .lo     (lo)
  );

endmodule
